mpu_read_scheduler: RTL and testbench
=====================================

# mpu_read_scheduler

Sequencer in front of the I2C master. After `enable` it runs the MPU initialisation once, then triggers a 14-byte burst read at a fixed sample rate. It assembles the returned bytes into seven signed 16-bit samples and publishes them with a one-cycle valid strobe. It sits between the I2C master and the attitude-estimation datapath, and owns the master's `en_start` / `read_now` controls.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `SAMPLE_HZ`, 1000, burst-read rate. Period `P = CLK_HZ/SAMPLE_HZ` cycles; integer division, `P >= 2`.
- `TIMEOUT_CYC`, 200_000, maximum cycles allowed in INIT_WAIT or COLLECT.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `enable`  in  1  run request, level-sensitive.
- `iic_en_start`  out  1  one-cycle pulse that starts MPU initialisation in the master.
- `iic_init_done`  in  1  level from the master; high once initialisation has completed.
- `iic_read_now`  out  1  one-cycle pulse that starts a 14-byte burst read.
- `iic_data_avalid`  in  1  one-cycle strobe; `iic_data` is valid in that cycle.
- `iic_data`  in  8  received byte.
- `accel_x`, `accel_y`, `accel_z`, `temp`, `gyro_x`, `gyro_y`, `gyro_z`  out  16 each  signed samples, held between publishes.
- `sample_valid`  out  1  one-cycle strobe; all seven sample outputs update in that same cycle.
- `busy`  out  1  high in every state except IDLE and ERROR.
- `err_timeout`  out  1  sticky; set on entry to ERROR.
- `missed_ticks`  out  8  saturating count of sample ticks dropped.

## Operation
- States and transitions:
  - IDLE → INIT_REQ when `enable`=1.
  - INIT_REQ: assert `iic_en_start` for one cycle, then go to INIT_WAIT.
  - INIT_WAIT → READY on `iic_init_done`=1.
  - READY → READ_REQ on a sample tick.
  - READ_REQ: assert `iic_read_now` for one cycle, clear the byte counter, then go to COLLECT.
  - COLLECT: each `iic_data_avalid` shifts `iic_data` in and increments the counter. The strobe that delivers byte 14 moves the FSM to PUBLISH.
  - PUBLISH: latch all outputs, pulse `sample_valid`. Next state is READY if `enable`=1, otherwise IDLE.
  - ERROR → IDLE when `enable`=0.
- Byte order is big-endian in MPU register order: byte0 = ACCEL_XOUT_H, byte1 = ACCEL_XOUT_L, and so on through byte13 = GYRO_ZOUT_L. Output mapping:
  - `accel_x` = {b0,b1}
  - `temp` = {b6,b7}
  - `gyro_z` = {b12,b13}
- Tick generator:
  - free-running down-counter, loaded with `P-1` on first entry to READY;
  - produces one tick every `P` cycles thereafter;
  - keeps running until IDLE or ERROR.
- A tick arriving in READ_REQ, COLLECT or PUBLISH is dropped and increments `missed_ticks`, which saturates at 255 and is cleared only by `rst`.
- Timeout:
  - the cycle counter resets on entry to INIT_WAIT and on entry to COLLECT;
  - reaching `TIMEOUT_CYC` in either state → ERROR, `err_timeout`=1, partial frame discarded.
  - `err_timeout` clears when ERROR exits to IDLE.
- `enable` deasserted:
  - in READY → IDLE next cycle;
  - in INIT_WAIT or COLLECT → the transaction completes, or times out, first;
  - in INIT_REQ or READ_REQ → the pulse is still issued.
- `iic_data_avalid` outside COLLECT is ignored. Bytes beyond the 14th cannot be captured, because the FSM has already left COLLECT.
- Re-enable after IDLE reruns initialisation (INIT_REQ).

## Timing
- Reset values:
  - all sample outputs 0;
  - `sample_valid`, `iic_en_start`, `iic_read_now`, `busy`, `err_timeout` all 0;
  - `missed_ticks` 0;
  - FSM in IDLE.
- `enable` rising → `iic_en_start` high 1 cycle later.
- Tick cycle → `iic_read_now` high the following cycle.
- 14th `iic_data_avalid` at cycle t → `sample_valid` high and outputs updated at t+1.
- All outputs are registered; no combinational path from inputs to outputs.
- When a tick coincides with the PUBLISH cycle, the tick is dropped, not queued.
- `rst` mid-COLLECT: immediate asynchronous return to IDLE; held sample values reset to 0.

## Structure
- Package `mpu_sched_pkg`: state enum, `FRAME_BYTES`=14, byte-offset constants for the seven words, `MISSED_W`=8.
- Sub-module `sample_tick_gen` holds the period counter with load/enable/tick ports, parameterised by `P`. The FSM, timeout counter, 112-bit shift register and output latches stay in the top level.

## Test plan
- Reset, `enable`=1 → `iic_en_start` pulse 1 cycle later; after `iic_init_done`, the first `iic_read_now` arrives `P` cycles after entry to READY.
- Master model returns bytes 0x01..0x0E → `accel_x`=0x0102, `temp`=0x0708, `gyro_z`=0x0D0E, `sample_valid` for exactly one cycle, one cycle after byte 14.
- Master model returns only 9 bytes → ERROR after `TIMEOUT_CYC` cycles, `err_timeout`=1, no `sample_valid`; dropping `enable` → IDLE with `err_timeout`=0.
- Collection stretched over 2.5·`P` → `missed_ticks`=2 and the next read issued on the following tick; with 300 forced misses, `missed_ticks` saturates at 255.
- `enable` dropped mid-COLLECT → frame completes and is published, FSM goes to IDLE, no further `iic_read_now`.
- `rst` asserted mid-COLLECT → outputs 0 and FSM in IDLE in the same cycle; re-enable reissues `iic_en_start`.

Source files
------------

// File: rtl/mpu_sched_pkg.sv
// Shared types and constants for the MPU read scheduler: FSM states, frame
// geometry and the word-extraction helper used on the captured burst.
package mpu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_REQ,
    S_INIT_WAIT,
    S_READY,
    S_READ_REQ,
    S_COLLECT,
    S_PUBLISH,
    S_ERROR
  } state_e;

  localparam int FRAME_BYTES = 14;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;
  localparam int MISSED_W    = 8;

  localparam int OFF_ACCEL_X = 0;
  localparam int OFF_ACCEL_Y = 2;
  localparam int OFF_ACCEL_Z = 4;
  localparam int OFF_TEMP    = 6;
  localparam int OFF_GYRO_X  = 8;
  localparam int OFF_GYRO_Y  = 10;
  localparam int OFF_GYRO_Z  = 12;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Byte 0 of the burst sits in the MSBs, so offsets count down from the top.
  function automatic logic [15:0] word_at(input frame_t f, input int off);
    return f[FRAME_BITS-1-8*off -: 16];
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running period counter: one-cycle tick every P enabled cycles after a load.
// Tick is combinational from the counter register; load takes priority over enable.
module sample_tick_gen #(
  parameter int P = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] RELOAD = CW'(P - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/mpu_read_scheduler.sv
// Drives MPU init and periodic 14-byte burst reads through the I2C master,
// assembles seven big-endian words and publishes them with a one-cycle strobe.
module mpu_read_scheduler
  import mpu_sched_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 1000,
  parameter int TIMEOUT_CYC = 200_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                iic_en_start,
  input  logic                iic_init_done,
  output logic                iic_read_now,
  input  logic                iic_data_avalid,
  input  logic [7:0]          iic_data,
  output logic signed [15:0]  accel_x,
  output logic signed [15:0]  accel_y,
  output logic signed [15:0]  accel_z,
  output logic signed [15:0]  temp,
  output logic signed [15:0]  gyro_x,
  output logic signed [15:0]  gyro_y,
  output logic signed [15:0]  gyro_z,
  output logic                sample_valid,
  output logic                busy,
  output logic                err_timeout,
  output logic [MISSED_W-1:0] missed_ticks
);

  localparam int P    = CLK_HZ / SAMPLE_HZ;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BC_W = $clog2(FRAME_BYTES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BYTES - 1);

  state_e              state_q, state_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [MISSED_W-1:0] missed_q, missed_d;
  frame_t              shift_q, shift_d, sample_q, sample_d;
  logic                en_start_q, en_start_d, read_now_q, read_now_d;
  logic                valid_q, valid_d, busy_q, busy_d, err_q, err_d;
  logic                tick, tick_load, tick_en, timed_out, last_byte;

  assign timed_out = (to_cnt_q == TO_LAST);
  assign last_byte = iic_data_avalid && (byte_cnt_q == BC_LAST);
  assign tick_en   = state_q inside {S_READY, S_READ_REQ, S_COLLECT, S_PUBLISH};
  assign tick_load = (state_q == S_INIT_WAIT) && iic_init_done;

  sample_tick_gen #(.P(P)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (tick_load),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Completion beats timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (enable) state_d = S_INIT_REQ;
      S_INIT_REQ:  state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (iic_init_done) state_d = S_READY;
                   else if (timed_out) state_d = S_ERROR;
      S_READY:     if (!enable) state_d = S_IDLE;
                   else if (tick) state_d = S_READ_REQ;
      S_READ_REQ:  state_d = S_COLLECT;
      S_COLLECT:   if (last_byte) state_d = S_PUBLISH;
                   else if (timed_out) state_d = S_ERROR;
      S_PUBLISH:   state_d = enable ? S_READY : S_IDLE;
      S_ERROR:     if (!enable) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are registered against the next state so they line up with state_q.
  always_comb begin
    en_start_d = (state_d == S_INIT_REQ);
    read_now_d = (state_d == S_READ_REQ);
    valid_d    = (state_d == S_PUBLISH);
    busy_d     = !(state_d inside {S_IDLE, S_ERROR});
    err_d      = (state_d == S_ERROR);
    sample_d   = sample_q;
    if (state_q == S_COLLECT && state_d == S_PUBLISH) begin
      sample_d = {shift_q[FRAME_BITS-9:0], iic_data};
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    to_cnt_d   = to_cnt_q;
    missed_d   = missed_q;
    if (state_q == S_READ_REQ) byte_cnt_d = '0;
    if (state_q == S_COLLECT && iic_data_avalid) begin
      byte_cnt_d = byte_cnt_q + BC_W'(1);
      shift_d    = {shift_q[FRAME_BITS-9:0], iic_data};
    end
    if (state_d != state_q) to_cnt_d = '0;
    else if (state_q inside {S_INIT_WAIT, S_COLLECT}) to_cnt_d = to_cnt_q + TO_W'(1);
    if (tick && state_q inside {S_READ_REQ, S_COLLECT, S_PUBLISH} && missed_q != '1) begin
      missed_d = missed_q + MISSED_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      sample_q   <= '0;
      to_cnt_q   <= '0;
      missed_q   <= '0;
      en_start_q <= 1'b0;
      read_now_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      to_cnt_q   <= to_cnt_d;
      missed_q   <= missed_d;
      en_start_q <= en_start_d;
      read_now_q <= read_now_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign iic_en_start = en_start_q;
  assign iic_read_now = read_now_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign missed_ticks = missed_q;
  assign accel_x      = word_at(sample_q, OFF_ACCEL_X);
  assign accel_y      = word_at(sample_q, OFF_ACCEL_Y);
  assign accel_z      = word_at(sample_q, OFF_ACCEL_Z);
  assign temp         = word_at(sample_q, OFF_TEMP);
  assign gyro_x       = word_at(sample_q, OFF_GYRO_X);
  assign gyro_y       = word_at(sample_q, OFF_GYRO_Y);
  assign gyro_z       = word_at(sample_q, OFF_GYRO_Z);

endmodule

// File: tb/tb_mpu_read_scheduler.sv
// Directed bench for mpu_read_scheduler with a scripted I2C master (P = 20 cycles).
module tb_mpu_read_scheduler;

  localparam int CLK_HZ      = 20_000;
  localparam int SAMPLE_HZ   = 1000;
  localparam int TIMEOUT_CYC = 7000;
  localparam int P           = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        iic_init_done = 1'b0;
  logic        iic_data_avalid = 1'b0;
  logic [7:0]  iic_data = 8'h00;
  logic        iic_en_start, iic_read_now, sample_valid, busy, err_timeout;
  logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
  logic [7:0]  missed_ticks;

  int tests = 0;
  int fails = 0;

  mpu_read_scheduler #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .iic_en_start(iic_en_start), .iic_init_done(iic_init_done),
    .iic_read_now(iic_read_now), .iic_data_avalid(iic_data_avalid), .iic_data(iic_data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .busy(busy), .err_timeout(err_timeout),
    .missed_ticks(missed_ticks)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has already stepped into COLLECT; bytes land on consecutive edges.
  task automatic send_frame(input int idle, input logic [7:0] base, input int nbytes,
                            input int drop_at);
    repeat (idle) step();
    for (int k = 0; k < nbytes; k++) begin
      if (k == drop_at) enable = 1'b0;
      iic_data        = base + 8'(k);
      iic_data_avalid = 1'b1;
      step();
    end
    iic_data_avalid = 1'b0;
  endtask

  task automatic wait_read_now(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (iic_read_now !== 1'b1 && n < 200);
  endtask

  task automatic wait_en_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (iic_en_start !== 1'b1 && n < 200);
  endtask

  task automatic test_reset();
    step();
    step();
    tests++;
    if ({accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== 112'h0) begin
      fails++;
      $display("FAIL reset_samples: got %h want 0",
               {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z});
    end
    tests++;
    if ({sample_valid, iic_en_start, iic_read_now, busy, err_timeout} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000",
               {sample_valid, iic_en_start, iic_read_now, busy, err_timeout});
    end
    tests++;
    if (missed_ticks !== 8'd0) begin
      fails++;
      $display("FAIL reset_missed: got %0d want 0", missed_ticks);
    end
    rst = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_init_first_read();
    int n;
    enable = 1'b1;
    step();
    tests++;
    if ({iic_en_start, busy} !== 2'b11) begin
      fails++;
      $display("FAIL en_start_pulse: got en_start/busy %b want 11", {iic_en_start, busy});
    end
    step();
    tests++;
    if (iic_en_start !== 1'b0) begin
      fails++;
      $display("FAIL en_start_width: got %b want 0", iic_en_start);
    end
    iic_init_done = 1'b1;
    wait_read_now(n);
    tests++;
    if (n !== P + 1) begin
      fails++;
      $display("FAIL first_read_latency: got %0d cycles want %0d", n, P + 1);
    end
  endtask

  task automatic test_frame();
    int n;
    step();
    tests++;
    if (iic_read_now !== 1'b0) begin
      fails++;
      $display("FAIL read_now_width: got %b want 0", iic_read_now);
    end
    send_frame(0, 8'h01, 14, -1);
    tests++;
    if (sample_valid !== 1'b1) begin
      fails++;
      $display("FAIL frame_valid: got %b want 1", sample_valid);
    end
    tests++;
    if ({accel_x, accel_y, accel_z, temp} !== 64'h0102_0304_0506_0708) begin
      fails++;
      $display("FAIL frame_accel_temp: got %h want 0102030405060708",
               {accel_x, accel_y, accel_z, temp});
    end
    tests++;
    if ({gyro_x, gyro_y, gyro_z} !== 48'h090A_0B0C_0D0E) begin
      fails++;
      $display("FAIL frame_gyro: got %h want 090a0b0c0d0e", {gyro_x, gyro_y, gyro_z});
    end
    step();
    tests++;
    if ({sample_valid, accel_x, missed_ticks} !== {1'b0, 16'h0102, 8'd0}) begin
      fails++;
      $display("FAIL frame_hold: got valid %b accel_x %h missed %0d want 0 0102 0",
               sample_valid, accel_x, missed_ticks);
    end
    wait_read_now(n);
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL tick_cadence: got %0d cycles want 4", n);
    end
  endtask

  task automatic test_missed_ticks();
    int n;
    step();
    send_frame(35, 8'h41, 14, -1);
    tests++;
    if ({sample_valid, accel_x} !== {1'b1, 16'h4142}) begin
      fails++;
      $display("FAIL stretch_frame: got valid %b accel_x %h want 1 4142", sample_valid, accel_x);
    end
    tests++;
    if (missed_ticks !== 8'd2) begin
      fails++;
      $display("FAIL stretch_missed: got %0d want 2", missed_ticks);
    end
    wait_read_now(n);
    tests++;
    if (n !== 10) begin
      fails++;
      $display("FAIL next_tick_read: got %0d cycles want 10", n);
    end
  endtask

  task automatic test_enable_drop();
    int seen;
    step();
    send_frame(0, 8'h21, 14, 5);
    tests++;
    if ({sample_valid, accel_x, temp, gyro_z} !== {1'b1, 48'h2122_2728_2D2E}) begin
      fails++;
      $display("FAIL drop_publish: got valid %b words %h want 1 212227282d2e",
               sample_valid, {accel_x, temp, gyro_z});
    end
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_idle: got busy %b want 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (iic_read_now === 1'b1 || iic_en_start === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL drop_quiet: got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_timeout();
    int n;
    int sv;
    enable = 1'b1;
    wait_en_start(n);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL reenable_en_start: got %0d cycles want 1", n);
    end
    wait_read_now(n);
    tests++;
    if (n !== P + 2) begin
      fails++;
      $display("FAIL reenable_read: got %0d cycles want %0d", n, P + 2);
    end
    step();
    send_frame(0, 8'h51, 9, -1);
    n  = 0;
    sv = 0;
    do begin
      step();
      n++;
      if (sample_valid === 1'b1) sv++;
    end while (err_timeout !== 1'b1 && n < TIMEOUT_CYC + 100);
    tests++;
    if (n !== TIMEOUT_CYC - 9) begin
      fails++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT_CYC - 9);
    end
    tests++;
    if ({sv[7:0], busy, accel_x} !== {8'd0, 1'b0, 16'h2122}) begin
      fails++;
      $display("FAIL timeout_discard: got valids %0d busy %b accel_x %h want 0 0 2122",
               sv, busy, accel_x);
    end
    tests++;
    if (missed_ticks !== 8'd255) begin
      fails++;
      $display("FAIL missed_saturate: got %0d want 255", missed_ticks);
    end
    repeat (3) step();
    tests++;
    if (err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL error_sticky: got %b want 1", err_timeout);
    end
    enable = 1'b0;
    step();
    tests++;
    if ({err_timeout, busy} !== 2'b00) begin
      fails++;
      $display("FAIL error_exit: got err/busy %b want 00", {err_timeout, busy});
    end
  endtask

  task automatic test_rst_mid_collect();
    int n;
    enable = 1'b1;
    wait_en_start(n);
    wait_read_now(n);
    step();
    send_frame(0, 8'h61, 4, -1);
    rst = 1'b1;
    #1;
    tests++;
    if ({accel_x, temp, gyro_z, busy, missed_ticks, sample_valid} !== 57'h0) begin
      fails++;
      $display("FAIL async_reset: got words %h busy %b missed %0d valid %b want all 0",
               {accel_x, temp, gyro_z}, busy, missed_ticks, sample_valid);
    end
    #2;
    rst = 1'b0;
    wait_en_start(n);
    tests++;
    if ({n[7:0], busy} !== {8'd1, 1'b1}) begin
      fails++;
      $display("FAIL reset_reinit: got %0d cycles busy %b want 1 1", n, busy);
    end
  endtask

  initial begin
    test_reset();
    test_init_first_read();
    test_frame();
    test_missed_ticks();
    test_enable_drop();
    test_timeout();
    test_rst_mid_collect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
